// File: rtl/tag_bank_ctrl_pkg.sv
// Shared types for the tag bank controller: default geometry, tag word layout
// and the flush FSM state encoding (used when TAG_FLUSH_EN is defined).
package tag_bank_ctrl_pkg;

  localparam int unsigned LINES_DEFAULT = 512;
  localparam int unsigned TAG_W_DEFAULT = 20;

  typedef struct packed {
    logic                     valid;
    logic [TAG_W_DEFAULT-1:0] tag;
  } tag_word_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } flush_state_t;

endpackage

// File: rtl/tag_bank_ctrl.sv
// Tag bank controller: port A reads for lookups, port B writes for fills, invalidates
// and the optional whole-bank sweep (macro TAG_FLUSH_EN; sweep also runs after reset).
module tag_bank_ctrl
  import tag_bank_ctrl_pkg::*;
#(
  parameter int unsigned LINES = LINES_DEFAULT,
  parameter int unsigned TAG_W = TAG_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lookup_valid,
  output logic                     lookup_ready,
  input  logic [$clog2(LINES)-1:0] lookup_line,
  input  logic [TAG_W-1:0]         lookup_tag,
  output logic                     result_valid,
  output logic                     result_hit,
  input  logic                     upd_valid,
  output logic                     upd_ready,
  input  logic [$clog2(LINES)-1:0] upd_line,
  input  logic [TAG_W-1:0]         upd_tag,
  input  logic                     upd_inval,
  input  logic                     flush_req,
  output logic                     flush_busy,
  output logic [$clog2(LINES)-1:0] addr_a,
  output logic                     en_a,
  output logic                     wen_a,
  output logic [TAG_W:0]           data_in_a,
  input  logic [TAG_W:0]           data_out_a,
  output logic [$clog2(LINES)-1:0] addr_b,
  output logic                     en_b,
  output logic                     wen_b,
  output logic [TAG_W:0]           data_in_b,
  input  logic [TAG_W:0]           data_out_b
);

  localparam int unsigned LW = $clog2(LINES);

  logic            w_flushing;
  logic [LW-1:0]   w_flush_line;
  logic            w_lk_acc;
  logic            w_upd_acc;
  logic [TAG_W:0]  w_upd_word;
  logic [TAG_W:0]  w_word;
  logic            w_unused_in;

  logic            r_valid;
  logic [TAG_W-1:0] r_tag;
  logic [LW-1:0]   r_line;
  logic            r_fwd_we;
  logic [LW-1:0]   r_fwd_line;
  logic [TAG_W:0]  r_fwd_word;

`ifdef TAG_FLUSH_EN
  flush_state_t  r_state;
  flush_state_t  w_state_nx;
  logic [LW-1:0] r_cnt;
  logic [LW-1:0] w_cnt_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FLUSH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (flush_req) begin
          w_state_nx = S_FLUSH;
          w_cnt_nx   = '0;
        end
      end
      S_FLUSH: begin
        if (r_cnt == LW'(LINES - 1)) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign w_flushing   = (r_state == S_FLUSH);
  assign w_flush_line = r_cnt;
  assign w_unused_in  = ^data_out_b;
`else
  assign w_flushing   = 1'b0;
  assign w_flush_line = '0;
  assign w_unused_in  = ^{data_out_b, flush_req};
`endif

  assign flush_busy   = w_flushing;
  assign lookup_ready = ~w_flushing;
  assign upd_ready    = ~w_flushing;
  assign w_lk_acc     = lookup_valid & lookup_ready;
  assign w_upd_acc    = upd_valid & upd_ready;
  assign w_upd_word   = upd_inval ? '0 : {1'b1, upd_tag};

  assign addr_a    = lookup_line;
  assign en_a      = w_lk_acc;
  assign wen_a     = 1'b0;
  assign data_in_a = '0;

  assign addr_b    = w_flushing ? w_flush_line : upd_line;
  assign en_b      = w_upd_acc | w_flushing;
  assign wen_b     = w_upd_acc | w_flushing;
  assign data_in_b = w_flushing ? '0 : w_upd_word;

  // The write accepted alongside a lookup is captured and compared against the
  // registered lookup line next cycle, because the bank returns the stale word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_tag      <= '0;
      r_line     <= '0;
      r_fwd_we   <= 1'b0;
      r_fwd_line <= '0;
      r_fwd_word <= '0;
    end else begin
      r_valid    <= w_lk_acc;
      r_fwd_we   <= w_upd_acc;
      r_fwd_line <= upd_line;
      r_fwd_word <= w_upd_word;
      if (w_lk_acc) begin
        r_tag  <= lookup_tag;
        r_line <= lookup_line;
      end
    end
  end

  always_comb begin
    w_word = data_out_a;
    if (r_fwd_we && (r_fwd_line == r_line)) w_word = r_fwd_word;
  end

  assign result_valid = r_valid;
  assign result_hit   = r_valid & w_word[TAG_W] & (w_word[TAG_W-1:0] == r_tag);

endmodule

// File: tb/tb_tag_bank_ctrl.sv
// Bench for tag_bank_ctrl with a behavioural tag bank; expected results are queued at
// issue time and checked by an independent monitor. Exercises the TAG_FLUSH_EN sweep when defined.
module tb_tag_bank_ctrl;
  import tag_bank_ctrl_pkg::*;

  localparam int unsigned LINES = 16;
  localparam int unsigned TAG_W = 20;
  localparam int unsigned LW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lookup_valid = 1'b0, lookup_ready;
  logic [LW-1:0] lookup_line = '0;
  logic [TAG_W-1:0] lookup_tag = '0;
  logic result_valid, result_hit;
  logic upd_valid = 1'b0, upd_ready;
  logic [LW-1:0] upd_line = '0;
  logic [TAG_W-1:0] upd_tag = '0;
  logic upd_inval = 1'b0;
  logic flush_req = 1'b0, flush_busy;
  logic [LW-1:0] addr_a, addr_b;
  logic en_a, wen_a, en_b, wen_b;
  logic [TAG_W:0] data_in_a, data_in_b;
  logic [TAG_W:0] data_out_a = '0;
  logic [TAG_W:0] data_out_b = '0;

  tag_bank_ctrl #(.LINES(LINES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_ready(lookup_ready),
    .lookup_line(lookup_line), .lookup_tag(lookup_tag),
    .result_valid(result_valid), .result_hit(result_hit),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_line(upd_line),
    .upd_tag(upd_tag), .upd_inval(upd_inval),
    .flush_req(flush_req), .flush_busy(flush_busy),
    .addr_a(addr_a), .en_a(en_a), .wen_a(wen_a), .data_in_a(data_in_a), .data_out_a(data_out_a),
    .addr_b(addr_b), .en_b(en_b), .wen_b(wen_b), .data_in_b(data_in_b), .data_out_b(data_out_b)
  );

  always #5 clk = ~clk;

  logic [TAG_W:0] mem [LINES];
  initial for (int i = 0; i < int'(LINES); i++) mem[i] = '0;
  always @(posedge clk) begin
    if (en_a && !wen_a) data_out_a <= mem[addr_a];
    if (en_b && wen_b) mem[addr_b] <= data_in_b;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic hit;
    int   cyc;
  } exp_t;
  exp_t q[$];
  tag_word_t ref_mem [LINES];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (result_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result_hit", result_hit, e.hit);
          chk("result_cycle", cyc, e.cyc);
        end
      end else begin
        chk("hit_when_idle", result_hit, 0);
      end
    end
  end

  // exp_hit < 0 lets the reference model decide; otherwise it is the hand value.
  task automatic drive(input bit lv, input int ll, input int lt, input bit uv, input int ul,
                       input int ut, input bit ui, input bit fr, input int exp_hit);
    tag_word_t w;
    exp_t e;
    @(posedge clk); #1;
    lookup_valid = lv; lookup_line = LW'(ll); lookup_tag = TAG_W'(lt);
    upd_valid = uv; upd_line = LW'(ul); upd_tag = TAG_W'(ut); upd_inval = ui;
    flush_req = fr;
    if (lv) begin
      chk("lookup_ready", lookup_ready, 1);
      w = ref_mem[ll];
      if (uv && ul == ll) w = ui ? '0 : {1'b1, TAG_W'(ut)};
      e.hit = (exp_hit < 0) ? (w.valid && w.tag == TAG_W'(lt)) : exp_hit[0];
      e.cyc = cyc + 1;
      q.push_back(e);
    end
    if (uv) ref_mem[ul] = ui ? '0 : {1'b1, TAG_W'(ut)};
  endtask

  task automatic idle_inputs();
    lookup_valid = 0; upd_valid = 0; upd_inval = 0;
  endtask

  task automatic check_sweep(input string nm, input int hold);
    int busy = 0;
    int line = 0;
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (i >= hold) flush_req = 0;
      if (flush_busy) begin
        busy++;
        chk({nm, "_ready"}, {lookup_ready, upd_ready}, 2'b00);
        chk({nm, "_wr"}, {en_b, wen_b, addr_b, data_in_b}, {2'b11, LW'(line), {(TAG_W+1){1'b0}}});
        line++;
      end else if (busy > 0) begin
        done = 1;
      end
    end
    chk({nm, "_ended"}, done, 1);
    chk({nm, "_busy_cycles"}, busy, LINES);
    for (int i = 0; i < int'(LINES); i++) ref_mem[i] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < int'(LINES); i++) ref_mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_result", {result_valid, result_hit}, 2'b00);
`ifdef TAG_FLUSH_EN
    chk("rst_busy_ready", {flush_busy, lookup_ready, upd_ready}, 3'b100);
    @(posedge clk); #1; rst = 0;
    check_sweep("reset_sweep", 0);
`else
    chk("rst_busy_ready", {flush_busy, lookup_ready, upd_ready}, 3'b011);
    @(posedge clk); #1; rst = 0;
`endif

    // Fill then lookups (hit, tag off by one)
    drive(0, 0, 0, 1, 5, 'h1234, 0, 0, -1);
    drive(1, 5, 'h1234, 0, 0, 0, 0, 0, 1);
    drive(1, 5, 'h1235, 0, 0, 0, 0, 0, 0);
    // Same-cycle fill / invalidate forwarding
    drive(1, 7, 'hABC, 1, 7, 'hABC, 0, 0, 1);
    drive(1, 7, 'hABC, 1, 7, 'hABC, 1, 0, 0);
    drive(1, 5, 'h1234, 1, 6, 'h55, 0, 0, 1);
    drive(1, 6, 'h55, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1; idle_inputs();

`ifdef TAG_FLUSH_EN
    // Lookup accepted alongside flush_req still completes; held flush_req is ignored
    drive(1, 5, 'h1234, 0, 0, 0, 0, 1, 1);
    @(posedge clk); #1; idle_inputs();
    check_sweep("flush_sweep", 3);
    drive(1, 5, 'h1234, 0, 0, 0, 0, 0, 0);
    drive(1, 6, 'h55, 0, 0, 0, 0, 0, 0);
    drive(1, 7, 'hABC, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1; idle_inputs();
    repeat (2) @(posedge clk);

    // Reset in the middle of a sweep
    drive(0, 0, 0, 1, 3, 'h77, 0, 1, -1);
    @(posedge clk); #1; idle_inputs(); flush_req = 0;
    begin
      bit seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        if (flush_busy && en_b && addr_b == LW'(8)) seen = 1;
      end
      chk("reach_line8", seen, 1);
    end
    rst = 1;
    #1 chk("midflush_rst_state", {result_valid, flush_busy}, 2'b01);
    @(posedge clk); #1; rst = 0;
    check_sweep("restart_sweep", 0);
`else
    // flush_req must not touch the bank
    drive(0, 0, 0, 0, 0, 0, 0, 1, -1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) flush_req = 0;
      chk("noflush_state", {flush_busy, lookup_ready, en_b}, 3'b010);
    end
    drive(1, 5, 'h1234, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1; idle_inputs();
`endif

    for (int i = 0; i < 100; i++) begin
      drive(1, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 3) == 0), 0, -1);
    end
    @(posedge clk); #1; idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tag_bank_ctrl.md
TAG_BANK_CTRL -- requirements
Module: tag_bank_ctrl

Interface
REQ-001 SHALL have parameter LINES, default 512, meaning number of tag lines; power of two.
REQ-002 SHALL have parameter TAG_W, default 20, meaning stored tag bits; bank word width is TAG_W+1, with bit TAG_W as the valid bit.
REQ-003 SHALL have ports clk in 1 (the single clock) and rst in 1; rst is asynchronous and active-high.
REQ-004 SHALL have ports lookup_valid in 1, lookup_ready out 1, lookup_line in clog2(LINES), lookup_tag in TAG_W: the lookup request channel.
REQ-005 SHALL have ports result_valid out 1 and result_hit out 1: the lookup result.
REQ-006 SHALL have ports upd_valid in 1, upd_ready out 1, upd_line in clog2(LINES), upd_tag in TAG_W, upd_inval in 1: fill the line (upd_inval=0) or invalidate it (upd_inval=1).
REQ-007 SHALL have ports flush_req in 1 and flush_busy out 1: the whole-bank invalidate control.
REQ-008 SHALL have bank port A outputs addr_a clog2(LINES), en_a 1, wen_a 1, data_in_a TAG_W+1, and input data_out_a TAG_W+1.
REQ-009 SHALL have bank port B outputs addr_b, en_b, wen_b, data_in_b (widths as port A), and input data_out_b TAG_W+1, which is unused.

Function
REQ-010 SHALL use port A for reads only: wen_a=0, data_in_a=0, en_a=lookup_valid&lookup_ready, addr_a=lookup_line.
REQ-011 SHALL use port B for writes only: en_b=wen_b=1 on an accepted update or a flush write, else 0.
REQ-012 SHALL drive data_in_b={1'b1,upd_tag} on a fill and all-zeros on an invalidate or flush write.
REQ-013 SHALL assert result_valid exactly one cycle after lookup acceptance, for one cycle; it SHALL sustain one lookup per cycle back-to-back.
REQ-014 SHALL set result_hit = data_out_a[TAG_W] & (data_out_a[TAG_W-1:0] == registered lookup_tag) when result_valid=1; result_hit SHALL be 0 when result_valid=0.
REQ-015 SHALL forward a same-cycle port-B write to the accepted lookup's line: the result SHALL be computed from the written word, never from data_out_a (bank read/write collision is unchecked).
REQ-016 SHALL tie lookup_ready=upd_ready=~flushing; lookup and update SHALL be accepted simultaneously when both are valid.
REQ-017 SHALL implement an FSM with states IDLE and FLUSH: IDLE->FLUSH on flush_req; in FLUSH, counter 0..LINES-1 writes one line per cycle; FLUSH->IDLE after the line LINES-1 write.
REQ-018 SHALL assert flush_busy while in FLUSH; flush_busy SHALL deassert in the cycle after the last write.
REQ-019 SHALL ignore flush_req while in FLUSH; it SHALL NOT restart the counter.
REQ-020 SHALL NOT perform wrap-around of the flush counter past LINES-1.
REQ-021 SHALL NOT assert result_valid for any flush cycle; a lookup accepted the cycle before FLUSH entry SHALL still complete normally.

Reset
REQ-022 SHALL clear result_valid, result_hit and the registered lookup tag/line on rst.
REQ-023 SHALL reset the FSM to FLUSH with counter 0 when TAG_FLUSH_EN is defined, so flush_busy resets to 1 and the bank is swept after reset.
REQ-024 SHALL abandon any in-progress sweep on rst mid-flush and restart it from line 0.

Configuration
REQ-025 SHALL include the FSM, counter and flush_req/flush_busy behaviour only when macro TAG_FLUSH_EN is defined.
REQ-026 SHALL, without TAG_FLUSH_EN, ignore flush_req, tie flush_busy=0 and ready=1, and rely on the bank's zero initial contents.

Structure
REQ-027 SHALL take the tag word typedef (valid + tag) and the LINES/TAG_W defaults from the shared cva5 types package.
REQ-028 SHALL have no sub-module; the parent instantiates the tag bank beside this block.

Verification
REQ-029 SHALL cover: fill line 5 tag 0x1234, then lookup line 5 tag 0x1234 next cycle -> result_valid and result_hit=1 one cycle later; lookup tag 0x1235 -> hit=0.
REQ-030 SHALL cover: fill line 7 tag 0xABC in the same cycle as a lookup of line 7 tag 0xABC -> hit=1 via forwarding; same with upd_inval=1 -> hit=0.
REQ-031 SHALL cover: flush_req with LINES=16 -> flush_busy high exactly 16 cycles, ready=0 throughout, afterwards every lookup misses.
REQ-032 SHALL cover: rst asserted at flush line 8 -> sweep restarts at line 0 and completes LINES writes.
REQ-033 SHALL cover: 100 back-to-back random lookups and updates against a reference model -> one result per cycle, all results matching.
REQ-034 SHALL cover: build without TAG_FLUSH_EN -> flush_busy=0 from reset, flush_req has no effect on bank writes.
